stats_reader: RTL and testbench
===============================

STATS_READER -- requirements
Module: stats_reader

Interface
REQ-001 SHALL have parameter CLEAR_ON_READ, default 0: 1 = pulse clear_stats after each snapshot capture.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port snap_req  input  1  request a snapshot; sampled every cycle.
REQ-005 SHALL have port snap_busy  output  1  high from capture until last word accepted.
REQ-006 SHALL have ports total_cycles, total_conflicts, total_decisions, total_restarts, total_learned  input  32 each  live statistics.
REQ-007 SHALL have ports conflict_counter, level0_conflict_count  input  16 each  live statistics.
REQ-008 SHALL have port clear_stats  output  1  one-cycle clear pulse to the statistics block.
REQ-009 SHALL have port m_valid  output  1  stream word valid.
REQ-010 SHALL have port m_ready  input  1  stream sink ready.
REQ-011 SHALL have port m_data  output  32  stream word.
REQ-012 SHALL have port m_last  output  1  marks final word of a frame.
REQ-013 SHALL have port snap_dropped  output  8  count of snap_req ignored while busy.

Function
REQ-014 SHALL implement FSM states IDLE and SEND.
REQ-015 In IDLE with snap_req=1, SHALL capture all seven inputs into snapshot registers at that edge and enter SEND.
REQ-016 m_valid SHALL rise the cycle after capture, i.e. one cycle of latency from snap_req.
REQ-017 Payload order SHALL be total_cycles, total_conflicts, total_decisions, total_restarts, total_learned, then {conflict_counter, level0_conflict_count} with conflict_counter in bits [31:16].
REQ-018 A word transfers on a cycle with m_valid && m_ready; the word index SHALL advance only on a transfer.
REQ-019 While m_valid && !m_ready, m_data and m_last SHALL hold stable.
REQ-020 m_last SHALL be 1 only on the final word of a frame.
REQ-021 After the last word transfers, SHALL return to IDLE next cycle with m_valid=0; a frame SHALL be followed by at least one idle cycle.
REQ-022 Frame contents SHALL reflect only the captured values, unaffected by input changes during SEND.
REQ-023 snap_busy SHALL equal (state==SEND).
REQ-024 snap_req=1 while in SEND SHALL be ignored and SHALL increment snap_dropped, saturating at 255.
REQ-025 With CLEAR_ON_READ=1, clear_stats SHALL pulse for exactly one cycle, the cycle after capture; with CLEAR_ON_READ=0 it SHALL remain 0.
REQ-026 A single-cycle m_ready SHALL move at most one word per cycle; continuous m_ready SHALL deliver one word per cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, m_valid=0, m_last=0, m_data=0, clear_stats=0, snap_busy=0, snap_dropped=0, word index=0, frame sequence=0.
REQ-028 Reset during SEND SHALL abandon the frame; no partial frame resumes after reset.

Configuration
REQ-029 With macro STATS_READER_HDR_EN defined, SHALL prepend a header word {16'hA5C3, 8'd6, seq[7:0]}; the frame is 7 words.
REQ-030 The header seq SHALL start at 0 and increment on each completed frame, wrapping from 255 to 0.
REQ-031 Without STATS_READER_HDR_EN, SHALL emit no header and no seq logic; the frame is exactly 6 words.

Verification
REQ-032 No HDR: cycles=100, conflicts=7, decisions=9, restarts=1, learned=5, cc=3, l0=2, snap_req 1 cycle, m_ready=1 -> words 100,7,9,1,5,0x00030002 on consecutive cycles starting 1 cycle later; m_last on the 6th word only.
REQ-033 Backpressure: m_ready low for 4 cycles on word 2 -> m_data=7 held stable, no word lost or duplicated.
REQ-034 Inputs change during SEND (cycles=999) -> frame still carries 100.
REQ-035 snap_req held high through a 6-cycle frame -> snap_dropped=6 (including the cycle of the final word), and a new capture on the first IDLE cycle; 300 dropped requests -> snap_dropped=255.
REQ-036 CLEAR_ON_READ=1 -> clear_stats high exactly 1 cycle, the cycle after capture; HDR_EN: two frames -> headers 0xA5C30600 then 0xA5C30601.
REQ-037 rst_n asserted mid-frame at word 3 -> m_valid=0 immediately; the next snap_req yields a full fresh frame.

Source files
------------

// File: rtl/stats_reader.sv
// Snapshot reader: captures seven live statistics on snap_req and streams them
// out as one valid/ready frame. Optional header word enabled by STATS_READER_HDR_EN.
module stats_reader #(
    parameter int CLEAR_ON_READ = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snap_req,
    output logic        snap_busy,
    input  logic [31:0] total_cycles,
    input  logic [31:0] total_conflicts,
    input  logic [31:0] total_decisions,
    input  logic [31:0] total_restarts,
    input  logic [31:0] total_learned,
    input  logic [15:0] conflict_counter,
    input  logic [15:0] level0_conflict_count,
    output logic        clear_stats,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic [7:0]  snap_dropped,
    output logic        dbg_state_o
);

    // Stream handshake: a word moves on any cycle with m_valid && m_ready; while
    // m_valid is high and m_ready low, m_data/m_last hold and m_valid stays high.
`ifdef STATS_READER_HDR_EN
    localparam int NWORDS = 7;
`else
    localparam int NWORDS = 6;
`endif
    localparam logic [2:0] LAST_IDX = 3'(NWORDS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] cyc_q, cfl_q, dec_q, rst_q, lrn_q, pack_q;
    logic        clear_q;
    logic [7:0]  drop_q;
    logic        capture, xfer, last_word;
    logic [2:0]  pay_idx;
    logic [31:0] data_mux;

    assign capture   = (state_q == S_IDLE) && snap_req;
    assign last_word = (state_q == S_SEND) && (idx_q == LAST_IDX);
    assign xfer      = (state_q == S_SEND) && m_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                idx_d = 3'd0;
                if (snap_req) state_d = S_SEND;
            end
            S_SEND: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Snapshot registers load only on capture, so input changes during SEND are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= 32'd0;
            cfl_q  <= 32'd0;
            dec_q  <= 32'd0;
            rst_q  <= 32'd0;
            lrn_q  <= 32'd0;
            pack_q <= 32'd0;
        end else if (capture) begin
            cyc_q  <= total_cycles;
            cfl_q  <= total_conflicts;
            dec_q  <= total_decisions;
            rst_q  <= total_restarts;
            lrn_q  <= total_learned;
            pack_q <= {conflict_counter, level0_conflict_count};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_q <= 1'b0;
        end else begin
            clear_q <= (CLEAR_ON_READ != 0) && capture;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if ((state_q == S_SEND) && snap_req && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

`ifdef STATS_READER_HDR_EN
    logic [7:0] seq_q;

    // Sequence advances once per completed frame and wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= 8'd0;
        end else if (xfer && last_word) begin
            seq_q <= seq_q + 8'd1;
        end
    end

    assign pay_idx = idx_q - 3'd1;
`else
    assign pay_idx = idx_q;
`endif

    always_comb begin
        data_mux = 32'd0;
        case (pay_idx)
            3'd0:    data_mux = cyc_q;
            3'd1:    data_mux = cfl_q;
            3'd2:    data_mux = dec_q;
            3'd3:    data_mux = rst_q;
            3'd4:    data_mux = lrn_q;
            3'd5:    data_mux = pack_q;
            default: data_mux = 32'd0;
        endcase
`ifdef STATS_READER_HDR_EN
        if (idx_q == 3'd0) data_mux = {16'hA5C3, 8'd6, seq_q};
`endif
    end

    assign m_valid      = (state_q == S_SEND);
    assign m_data       = (state_q == S_SEND) ? data_mux : 32'd0;
    assign m_last       = last_word;
    assign snap_busy    = (state_q == S_SEND);
    assign clear_stats  = clear_q;
    assign snap_dropped = drop_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_stats_reader.sv
// Directed bench for stats_reader: table-driven frames plus hand-written
// backpressure, drop-counting, clear-on-read and mid-frame reset sequences.
module tb_stats_reader;

`ifdef STATS_READER_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NW = 6 + HDR;

    logic        clk, rst_n, snap_req, m_ready;
    logic [31:0] total_cycles, total_conflicts, total_decisions, total_restarts, total_learned;
    logic [15:0] conflict_counter, level0_conflict_count;
    logic        snap_busy, clear_stats, m_valid, m_last, dbg_state;
    logic [31:0] m_data;
    logic [7:0]  snap_dropped;
    logic        c_busy, c_clear, c_valid, c_last, c_dbg;
    logic [31:0] c_data;
    logic [7:0]  c_dropped;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0]  hdr_seq = 8'd0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] cyc, cfl, dec, rst, lrn;
        logic [15:0] cc, l0;
        logic [31:0] exp_pack;
    } vec_t;
    vec_t vecs[3];

    stats_reader #(.CLEAR_ON_READ(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .snap_req(snap_req), .snap_busy(snap_busy),
        .total_cycles(total_cycles), .total_conflicts(total_conflicts),
        .total_decisions(total_decisions), .total_restarts(total_restarts),
        .total_learned(total_learned), .conflict_counter(conflict_counter),
        .level0_conflict_count(level0_conflict_count), .clear_stats(clear_stats),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .snap_dropped(snap_dropped), .dbg_state_o(dbg_state)
    );

    stats_reader #(.CLEAR_ON_READ(1)) u_cor (
        .clk(clk), .rst_n(rst_n), .snap_req(snap_req), .snap_busy(c_busy),
        .total_cycles(total_cycles), .total_conflicts(total_conflicts),
        .total_decisions(total_decisions), .total_restarts(total_restarts),
        .total_learned(total_learned), .conflict_counter(conflict_counter),
        .level0_conflict_count(level0_conflict_count), .clear_stats(c_clear),
        .m_valid(c_valid), .m_ready(m_ready), .m_data(c_data), .m_last(c_last),
        .snap_dropped(c_dropped), .dbg_state_o(c_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        hdr_seq = 8'd0;
        tick();
    endtask

    // Driver tasks
    task automatic set_inputs(input vec_t v);
        total_cycles          = v.cyc;
        total_conflicts       = v.cfl;
        total_decisions       = v.dec;
        total_restarts        = v.rst;
        total_learned         = v.lrn;
        conflict_counter      = v.cc;
        level0_conflict_count = v.l0;
    endtask

    task automatic push_frame(input vec_t v);
        if (HDR != 0) exp_q.push_back({16'hA5C3, 8'd6, hdr_seq});
        exp_q.push_back(v.cyc);
        exp_q.push_back(v.cfl);
        exp_q.push_back(v.dec);
        exp_q.push_back(v.rst);
        exp_q.push_back(v.lrn);
        exp_q.push_back(v.exp_pack);
    endtask

    // One-cycle snap_req from IDLE; checks latency and the clear pulse.
    task automatic snap(input vec_t v);
        set_inputs(v);
        push_frame(v);
        snap_req = 1'b1;
        chk("pre_valid", m_valid, 1'b0);
        tick();
        snap_req = 1'b0;
        chk("valid_lat1", m_valid, 1'b1);
        chk("busy_send", snap_busy, 1'b1);
        chk("clr_cor_pulse", c_clear, 1'b1);
        chk("clr_nocor", clear_stats, 1'b0);
    endtask

    // Scoreboard: drains exp_q against the stream, optional stall or mid-frame reset.
    task automatic collect(input int stall_word, input int stall_cycles, input int abort_word);
        int   words = 0;
        int   stall_left = stall_cycles;
        int   cyc = 0;
        int   nexp = exp_q.size();
        bit   done = 0;
        bit   xfer;
        while (!done) begin
            if (cyc >= 200) begin
                chk("frame_timeout", 32'(words), 32'(nexp));
                exp_q.delete();
                m_ready = 1'b1;
                return;
            end
            if (abort_word >= 0 && words == abort_word) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", m_valid, 1'b0);
                chk("rst_busy", snap_busy, 1'b0);
                chk("rst_data", m_data, 32'd0);
                exp_q.delete();
                hdr_seq = 8'd0;
                m_ready = 1'b1;
                return;
            end
            m_ready = !(words == stall_word && stall_left > 0);
            chk("valid_in_frame", m_valid, 1'b1);
            chk("data", m_data, exp_q[0]);
            chk("last", m_last, (exp_q.size() == 1));
            if (cyc == 1) chk("clr_cor_once", c_clear, 1'b0);
            xfer = m_valid && m_ready;
            if (!m_ready) stall_left--;
            tick();
            cyc++;
            if (xfer) begin
                void'(exp_q.pop_front());
                words++;
                if (exp_q.size() == 0) begin
                    done    = 1;
                    hdr_seq = hdr_seq + 8'd1;
                end
            end
        end
        m_ready = 1'b1;
        chk("word_count", 32'(words), 32'(nexp));
        chk("idle_valid", m_valid, 1'b0);
        chk("idle_busy", snap_busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{cyc: 32'd100, cfl: 32'd7, dec: 32'd9, rst: 32'd1, lrn: 32'd5,
                    cc: 16'd3, l0: 16'd2, exp_pack: 32'h0003_0002};
        vecs[1] = '{cyc: 32'hFFFF_FFFF, cfl: 32'd0, dec: 32'h1234_5678, rst: 32'h8000_0000,
                    lrn: 32'd1, cc: 16'hFFFF, l0: 16'h0001, exp_pack: 32'hFFFF_0001};
        vecs[2] = '{cyc: 32'd0, cfl: 32'd1, dec: 32'd2, rst: 32'd3, lrn: 32'd4,
                    cc: 16'h1234, l0: 16'hABCD, exp_pack: 32'h1234_ABCD};

        snap_req = 1'b0;
        m_ready  = 1'b1;
        set_inputs(vecs[0]);
        do_reset();

        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_busy", snap_busy, 1'b0);
        chk("rst_dropped", snap_dropped, 8'd0);
        chk("rst_clear", clear_stats, 1'b0);
        chk("rst_cor_clear", c_clear, 1'b0);
        chk("rst_state", dbg_state, 1'b0);

        // Table-driven frames with continuous m_ready.
        for (int i = 0; i < 3; i++) begin
            snap(vecs[i]);
            collect(-1, 0, -1);
            tick();
        end

        // Backpressure on the second payload word.
        snap(vecs[0]);
        collect(HDR + 1, 4, -1);
        tick();

        // Inputs change during SEND; frame keeps captured values.
        snap(vecs[0]);
        total_cycles = 32'd999;
        total_learned = 32'd77;
        collect(-1, 0, -1);
        chk("dropped_still0", snap_dropped, 8'd0);
        tick();

        // snap_req held through a whole frame.
        set_inputs(vecs[2]);
        push_frame(vecs[2]);
        snap_req = 1'b1;
        tick();
        for (int w = 0; w < NW; w++) begin
            chk("held_data", m_data, exp_q[0]);
            void'(exp_q.pop_front());
            tick();
        end
        hdr_seq = hdr_seq + 8'd1;
        chk("held_idle_gap", m_valid, 1'b0);
        chk("held_dropped", snap_dropped, 8'(NW));
        set_inputs(vecs[1]);
        push_frame(vecs[1]);
        tick();
        chk("held_recapture", m_valid, 1'b1);
        m_ready = 1'b0;
        for (int k = 0; k < 300; k++) tick();
        chk("dropped_sat", snap_dropped, 8'd255);
        chk("cor_dropped_sat", c_dropped, 8'd255);
        snap_req = 1'b0;
        collect(-1, 0, -1);
        tick();

        // Reset asserted while word 3 is presented.
        snap(vecs[1]);
        collect(-1, 0, HDR + 3);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", m_valid, 1'b0);
        chk("post_rst_dropped", snap_dropped, 8'd0);
        snap(vecs[0]);
        collect(-1, 0, -1);
        tick();

        // Back-to-back frames check header sequencing (0, 1 after reset).
        snap(vecs[2]);
        if (HDR != 0) chk("hdr_seq1", m_data, 32'hA5C3_0601);
        collect(-1, 0, -1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
